// File: rtl/task1_uart_echo.sv
// UART loopback: an 8N1 receiver feeds a one-byte holding register,
// which is drained by an 8N1 transmitter running at the same bit rate.
module task1_uart_echo #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic tx
);

    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF = CLKS_PER_BIT / 2;

    // Last count of a full bit period and of the half period used to reach mid-start.
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;

    rx_state_t       rx_state;
    rx_state_t       rx_state_n;
    logic [CW-1:0]   rx_cnt;
    logic [CW-1:0]   rx_cnt_n;
    logic [2:0]      rx_bit;
    logic [2:0]      rx_bit_n;
    logic [7:0]      rx_shift;
    logic [7:0]      rx_shift_n;
    logic            rx_valid;

    logic [7:0]      hold;
    logic            full;

    tx_state_t       tx_state;
    tx_state_t       tx_state_n;
    logic [CW-1:0]   tx_cnt;
    logic [CW-1:0]   tx_cnt_n;
    logic [2:0]      tx_bit;
    logic [2:0]      tx_bit_n;
    logic [7:0]      tx_shift;
    logic [7:0]      tx_shift_n;
    logic            tx_load;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state, bit timer, bit index and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // Receiver next state: the edge is seen one clock after rx_sync falls, so the
    // start timer begins at 1 to keep every sample at mid-bit relative to that fall.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_valid   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                rx_bit_n = '0;
                if (rx_prev && !rx_sync) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = CW'(1);
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_n = RX_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n = '0;
                    if (rx_sync) begin
                        rx_valid   = 1'b1;
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync) begin
                    rx_state_n = RX_IDLE;
                end
            end
            default: begin
                rx_state_n = RX_IDLE;
            end
        endcase
    end

    // Holding register: a new byte is accepted only when empty, otherwise it is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold <= '0;
            full <= 1'b0;
        end else if (rx_valid && !full) begin
            hold <= rx_shift;
            full <= 1'b1;
        end else if (tx_load) begin
            full <= 1'b0;
        end
    end

    // Transmitter state plus the registered line, which follows the state one clock later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            case (tx_state)
                TX_START: tx <= 1'b0;
                TX_DATA:  tx <= tx_shift[0];
                default:  tx <= 1'b1;
            endcase
        end
    end

    // Transmitter next state: a waiting byte is taken straight from the end of the stop bit.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_load    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                tx_bit_n = '0;
                if (full) begin
                    tx_load    = 1'b1;
                    tx_shift_n = hold;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) begin
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_bit_n = tx_bit + 1'b1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    tx_bit_n = '0;
                    if (full) begin
                        tx_load    = 1'b1;
                        tx_shift_n = hold;
                        tx_state_n = TX_START;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_task1_uart_echo.sv
// Bench for the UART loopback: drives serial frames, decodes the echoed line and
// compares decoded bytes and bit timing against a byte-queue reference.
module tb_task1_uart_echo;

    localparam int CPB      = 16;
    localparam int CPB_SLOW = 434;

    logic clk;
    logic reset;
    logic rx;
    logic tx;
    logic rx434;
    logic tx434;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int drive_cyc  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         start_q[$];
    int         edge_q[$];

    task1_uart_echo #(.CLKS_PER_BIT(CPB)) u_dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .tx    (tx)
    );

    task1_uart_echo #(.CLKS_PER_BIT(CPB_SLOW)) u_dut434 (
        .clk   (clk),
        .reset (reset),
        .rx    (rx434),
        .tx    (tx434)
    );

    // 20 ns system clock.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Rising-edge counter used to timestamp stimulus and observed edges.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Sends one frame starting at the current negedge; leaves off at a negedge.
    task automatic applyStimulus(input logic [7:0] data, input logic stopbit, input bit slow);
        int cpb;
        cpb = slow ? CPB_SLOW : CPB;
        if (slow) rx434 = 1'b0; else rx = 1'b0;
        drive_cyc = cyc;
        repeat (cpb) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (slow) rx434 = data[k]; else rx = data[k];
            repeat (cpb) @(negedge clk);
        end
        if (slow) rx434 = stopbit; else rx = stopbit;
        repeat (cpb) @(negedge clk);
        if (slow) rx434 = 1'b1; else rx = 1'b1;
    endtask

    // Waits for every expected byte (bounded), allows time for stray frames, then compares.
    task automatic checkQueues(input string tag, input int budget);
        int waited;
        waited = 0;
        while (rx_q.size() < exp_q.size() && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        repeat (12 * CPB) @(negedge clk);
        checkOutput({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) begin
                checkOutput($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
            end
        end
        rx_q.delete();
        exp_q.delete();
        start_q.delete();
    endtask

    // Line decoder for the fast instance: finds a start bit and samples each bit at its centre.
    initial begin
        logic [7:0] b;
        @(posedge reset);
        forever begin
            do @(negedge clk); while (tx !== 1'b0);
            start_q.push_back(cyc);
            repeat (CPB / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge clk);
                b[k] = tx;
            end
            repeat (CPB) @(negedge clk);
            checkOutput("stop_bit", 32'(tx), 32'd1);
            rx_q.push_back(b);
        end
    end

    // Transition recorder for the slow instance.
    initial begin
        logic prev434;
        @(posedge reset);
        prev434 = 1'b1;
        forever begin
            @(negedge clk);
            if (tx434 !== prev434) begin
                edge_q.push_back(cyc);
                prev434 = tx434;
            end
        end
    end

    initial begin
        logic       low_seen;
        logic [7:0] d;
        int         waited;
        int         n_before;

        reset = 1'b1;
        rx    = 1'b1;
        rx434 = 1'b1;
        #3 reset = 1'b0;

        // Reset held with idle line: tx must stay high.
        low_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx434 !== 1'b1) low_seen = 1'b1;
        end
        checkOutput("reset_tx_high", 32'(tx), 32'd1);
        checkOutput("reset_tx_high_during", 32'(low_seen), 32'd0);
        reset = 1'b1;
        low_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        checkOutput("idle_after_reset", 32'(low_seen), 32'd0);

        // Single echo with latency: sync fall 2 clocks after drive, stop sample 9.5 bits later, tx start 2 clocks after that.
        applyStimulus(8'h55, 1'b1, 1'b0);
        exp_q.push_back(8'h55);
        waited = 0;
        while (start_q.size() == 0 && waited < 20 * CPB) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("echo_started", 32'(start_q.size() > 0), 32'd1);
        if (start_q.size() > 0) begin
            checkOutput("echo_latency", 32'(start_q[0] - drive_cyc), 32'(4 + (19 * CPB) / 2));
        end
        checkQueues("single", 20 * CPB);

        // Back-to-back directed and random bytes, no idle gap.
        applyStimulus(8'h00, 1'b1, 1'b0); exp_q.push_back(8'h00);
        applyStimulus(8'hFF, 1'b1, 1'b0); exp_q.push_back(8'hFF);
        applyStimulus(8'hA5, 1'b1, 1'b0); exp_q.push_back(8'hA5);
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            applyStimulus(d, 1'b1, 1'b0);
            exp_q.push_back(d);
        end
        checkQueues("b2b", 40 * CPB);

        // Glitch: 3-clock low pulse must not start a frame; receiver still works afterwards.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        checkOutput("glitch_no_frame", 32'(start_q.size()), 32'd0);
        d = 8'($urandom);
        applyStimulus(d, 1'b1, 1'b0);
        exp_q.push_back(d);
        checkQueues("after_glitch", 20 * CPB);

        // Framing error: bad frame is discarded, the next good frame echoes.
        applyStimulus(8'h3C, 1'b0, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        applyStimulus(8'h81, 1'b1, 1'b0);
        exp_q.push_back(8'h81);
        checkQueues("framing", 20 * CPB);

        // Reset during transmission: tx high at once and nothing more is sent.
        d = 8'($urandom);
        applyStimulus(d, 1'b1, 1'b0);
        waited = 0;
        while (start_q.size() == 0 && waited < 20 * CPB) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("midtx_started", 32'(start_q.size() > 0), 32'd1);
        repeat (3 * CPB) @(negedge clk);
        n_before = start_q.size();
        reset = 1'b0;
        #1;
        checkOutput("reset_async_tx", 32'(tx), 32'd1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        low_seen = 1'b0;
        repeat (15 * CPB) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        checkOutput("no_bits_after_reset", 32'(low_seen), 32'd0);
        checkOutput("no_start_after_reset", 32'(start_q.size()), 32'(n_before));
        rx_q.delete();
        start_q.delete();

        // Normal operation resumes after reset.
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            applyStimulus(d, 1'b1, 1'b0);
            exp_q.push_back(d);
        end
        checkQueues("post_reset", 30 * CPB);

        // Bit timing at 434 clocks per bit: 0x55 toggles the line at every bit boundary.
        edge_q.delete();
        applyStimulus(8'h55, 1'b1, 1'b1);
        waited = 0;
        while (edge_q.size() < 10 && waited < 20 * CPB_SLOW) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("baud_edges", 32'(edge_q.size() >= 10), 32'd1);
        for (int i = 1; i < 10; i++) begin
            if (i < edge_q.size()) begin
                checkOutput($sformatf("baud_bit%0d", i - 1), 32'(edge_q[i] - edge_q[i - 1]), 32'(CPB_SLOW));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/task1_uart_echo.md
# task1_uart_echo

UART loopback top level (DUT `task1`): receives 8N1 serial bytes on `rx` and retransmits each valid byte unchanged on `tx`. It is the first integration block of the FPGA project, sitting directly on the board's serial pins with a single system clock. It contains a receiver, a one-byte holding register and a transmitter, with no host-side interface.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz (20 ns period).
- `BAUD`, 115200: serial bit rate.
- `CLKS_PER_BIT`, CLK_FREQ/BAUD (434): clocks per bit. Overridable directly for simulation. Must be ≥ 8.

- `clk`  input  1  system clock; everything is rising-edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `rx`  input  1  serial input, idle high, asynchronous to `clk`.
- `tx`  output  1  serial output, idle high, registered.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- `rx` passes through a 2-flop synchronizer before any use.
- Receiver FSM:
  - IDLE: wait for a synchronized 1→0 transition → START.
  - START: count CLKS_PER_BIT/2. If the line is still 0 → DATA. Otherwise it is a glitch → IDLE.
  - DATA: sample every CLKS_PER_BIT clocks, 8 samples, shifted in LSB first → STOP.
  - STOP: sample after CLKS_PER_BIT. A 1 gives a valid byte, written to the holding register. A 0 is a framing error: the byte is discarded and the receiver does not re-arm until `rx` has been seen high.
- Holding register: one byte plus a `full` flag.
  - Written by the receiver on a valid stop.
  - Consumed by the transmitter when it is idle.
  - If `full` is already set when a new valid byte arrives, the new byte is dropped (overrun); the held byte is preserved.
- Transmitter FSM:
  - IDLE: `tx`=1. When `full` is set, load the byte, clear `full` → START.
  - START: `tx`=0 for CLKS_PER_BIT.
  - DATA: 8 bits LSB first, CLKS_PER_BIT each.
  - STOP: `tx`=1 for CLKS_PER_BIT → IDLE.
- Receiver and transmitter run concurrently. Back-to-back frames at the same baud echo without loss.

## Timing
- Reset (`reset`=0, asynchronous):
  - `tx`=1 immediately.
  - Both FSMs go to IDLE; counters and shift registers are cleared.
  - `full` is cleared; synchronizer flops are set to 1.
- Reset asserted mid-frame aborts both frames. After release, the receiver waits for a fresh falling edge.
- Data sampling occurs at mid-bit: (k+1.5)·CLKS_PER_BIT clocks after the synchronized start edge, for data bit k.
- Latency:
  - `full` is set on the clock after the valid stop sample.
  - The transmitter loads on the next clock, and `tx` falls (start bit) on the clock after that.
  - Stop-sample to `tx` start-bit edge is therefore 2 clocks when the transmitter is idle.
- Each transmitted bit lasts exactly CLKS_PER_BIT clocks. A frame is 10·CLKS_PER_BIT clocks.
- If a valid byte arrives while the transmitter is busy, the byte waits in the holding register and starts the clock after the current stop bit ends.
- A write to the holding register and a transmitter load in the same clock is not possible by construction, because the load follows `full`.

## Test plan
- Reset: hold `reset`=0 with `rx`=1, then release → `tx` stays 1 throughout. Assert `reset` mid-transmission → `tx`=1 within the same cycle, and no further bits are sent.
- Single echo (CLKS_PER_BIT=16): send 0x55 on `rx` → `tx` emits start, 1,0,1,0,1,0,1,0, stop. The start edge is 2 clocks after the rx stop-bit mid-sample. Decode equals 0x55.
- Back-to-back: send 0x00, 0xFF, 0xA5 with no idle gap → `tx` emits 0x00, 0xFF, 0xA5 in order, none lost.
- Glitch rejection: pulse `rx` low for 3 clocks → no frame on `tx`, and the receiver is back in IDLE.
- Framing error: send 0x3C with stop bit 0, then hold `rx` high, then send 0x81 → only 0x81 appears on `tx`.
- Baud accuracy (CLKS_PER_BIT=434): each `tx` bit lasts exactly 434 clocks (8680 ns at 20 ns period).
